// File: rtl/axi_stream_constant_sequencer_pkg.sv
// Shared types and widths for the constant-beat stream sequencer.
// Descriptors are queued as desc_t words; the player FSM uses state_t.
package axi_stream_constant_sequencer_pkg;

  localparam int unsigned C_DATA_OUT_DATA_WIDTH = 8;
  localparam int unsigned C_COUNT_WIDTH         = 41;
  localparam int unsigned C_FIFO_DEPTH_LOG2     = 2;
  localparam int unsigned LEVEL_WIDTH           = C_FIFO_DEPTH_LOG2 + 1;

  typedef struct packed {
    logic                             last;
    logic [C_COUNT_WIDTH-1:0]         count;
    logic [C_DATA_OUT_DATA_WIDTH-1:0] value;
  } desc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/axi_stream_constant_sequencer_if.sv
// Descriptor input channel and beat output channel of the sequencer.
// slave is the sequencer's view; master is the control/consumer view.
interface axi_stream_constant_sequencer_if;
  import axi_stream_constant_sequencer_pkg::*;

  logic                             desc_tvalid;
  logic                             desc_tready;
  logic [C_DATA_OUT_DATA_WIDTH-1:0] desc_value;
  logic [C_COUNT_WIDTH-1:0]         desc_count;
  logic                             desc_last;

  logic                             data_out_tvalid;
  logic [C_DATA_OUT_DATA_WIDTH-1:0] data_out_tdata;
  logic                             data_out_tlast;
  logic                             data_out_tready;

  modport slave (
    input  desc_tvalid, desc_value, desc_count, desc_last, data_out_tready,
    output desc_tready, data_out_tvalid, data_out_tdata, data_out_tlast
  );

  modport master (
    output desc_tvalid, desc_value, desc_count, desc_last, data_out_tready,
    input  desc_tready, data_out_tvalid, data_out_tdata, data_out_tlast
  );

endinterface

// File: rtl/axi_stream_constant_sequencer_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous flush.
// Read data is the head entry, visible combinationally while not empty.
module axi_stream_constant_sequencer_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr & ~full;
  assign do_rd   = rd & ~empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr && !flush && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axi_stream_constant_sequencer_wrapper.sv
// Flat-port wrapper so block-design tools can instantiate the sequencer
// without handling the SystemVerilog interface.
module axi_stream_constant_sequencer_wrapper
  import axi_stream_constant_sequencer_pkg::*;
(
  input  wire                             aclk,
  input  wire                             reset,
  input  wire                             desc_tvalid,
  output wire                             desc_tready,
  input  wire [C_DATA_OUT_DATA_WIDTH-1:0] desc_value,
  input  wire [C_COUNT_WIDTH-1:0]         desc_count,
  input  wire                             desc_last,
  input  wire                             abort,
  output wire                             data_out_tvalid,
  output wire [C_DATA_OUT_DATA_WIDTH-1:0] data_out_tdata,
  output wire                             data_out_tlast,
  input  wire                             data_out_tready,
  output wire                             desc_done,
  output wire                             busy,
  output wire [LEVEL_WIDTH-1:0]           fifo_level
);

  axi_stream_constant_sequencer_if bus ();

  assign bus.desc_tvalid     = desc_tvalid;
  assign bus.desc_value      = desc_value;
  assign bus.desc_count      = desc_count;
  assign bus.desc_last       = desc_last;
  assign bus.data_out_tready = data_out_tready;
  assign desc_tready         = bus.desc_tready;
  assign data_out_tvalid     = bus.data_out_tvalid;
  assign data_out_tdata      = bus.data_out_tdata;
  assign data_out_tlast      = bus.data_out_tlast;

  axi_stream_constant_sequencer u_core (
    .aclk       (aclk),
    .reset      (reset),
    .abort      (abort),
    .bus        (bus.slave),
    .desc_done  (desc_done),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

endmodule

// File: rtl/axi_stream_constant_sequencer.sv
// Plays queued (value, count, last) descriptors as back-to-back bursts of
// identical AXI-Stream beats, with abort and per-descriptor completion pulse.
module axi_stream_constant_sequencer
  import axi_stream_constant_sequencer_pkg::*;
(
  input  logic                             aclk,
  input  logic                             reset,
  input  logic                             abort,
  axi_stream_constant_sequencer_if.slave   bus,
  output logic                             desc_done,
  output logic                             busy,
  output logic [LEVEL_WIDTH-1:0]           fifo_level
);

  desc_t                            wr_desc;
  desc_t                            head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             fifo_wr;
  logic                             pop;
  logic                             zero_pop;
  logic                             head_zero;
  logic                             xfer;
  logic                             final_xfer;

  state_t                           state;
  logic [C_DATA_OUT_DATA_WIDTH-1:0] cur_value;
  logic                             cur_last;
  logic [C_COUNT_WIDTH-1:0]         remaining;

  assign wr_desc = '{last: bus.desc_last, count: bus.desc_count, value: bus.desc_value};
  assign bus.desc_tready = ~fifo_full & ~abort & ~reset;
  assign fifo_wr = bus.desc_tvalid & bus.desc_tready;

  axi_stream_constant_sequencer_sync_fifo #(
    .WIDTH      ($bits(desc_t)),
    .DEPTH_LOG2 (C_FIFO_DEPTH_LOG2)
  ) u_desc_fifo (
    .clk     (aclk),
    .reset   (reset),
    .flush   (abort),
    .wr      (fifo_wr),
    .wr_data (wr_desc),
    .rd      (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign xfer       = (state == STREAM) & bus.data_out_tready;
  assign final_xfer = xfer & (remaining == C_COUNT_WIDTH'(1));
  assign head_zero  = (head.count == '0);
  // A zero-count head waits for IDLE so two completions never share a cycle.
  assign pop        = ~fifo_empty & ~abort &
                      ((state == IDLE) | (final_xfer & ~head_zero));
  assign zero_pop   = pop & head_zero;

  assign bus.data_out_tvalid = (state == STREAM);
  assign bus.data_out_tdata  = cur_value;
  assign bus.data_out_tlast  = (state == STREAM) & cur_last &
                               (remaining == C_COUNT_WIDTH'(1));
  assign busy = (state == STREAM) | (fifo_level != '0);

  always_ff @(posedge aclk) begin
    if (reset) begin
      state     <= IDLE;
      cur_value <= '0;
      cur_last  <= 1'b0;
      remaining <= '0;
      desc_done <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      remaining <= '0;
      desc_done <= 1'b0;
    end else begin
      desc_done <= final_xfer | zero_pop;
      if (pop && !head_zero) begin
        state     <= STREAM;
        cur_value <= head.value;
        cur_last  <= head.last;
        remaining <= head.count;
      end else if (final_xfer) begin
        state     <= IDLE;
        remaining <= '0;
      end else if (xfer) begin
        remaining <= remaining - C_COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_constant_sequencer.sv
// Directed bench for the constant-beat sequencer: bursts, back-to-back,
// backpressure, zero count, full queue, abort, reset and a maximal count.
module tb_axi_stream_constant_sequencer;
  import axi_stream_constant_sequencer_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   abort;
  logic                   desc_done;
  logic                   busy;
  logic [LEVEL_WIDTH-1:0] fifo_level;
  int                     errors = 0;
  int                     checks = 0;

  localparam logic [C_COUNT_WIDTH-1:0] MAX_COUNT = '1;

  axi_stream_constant_sequencer_if bus ();

  axi_stream_constant_sequencer dut (
    .aclk       (clk),
    .reset      (reset),
    .abort      (abort),
    .bus        (bus.slave),
    .desc_done  (desc_done),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic [C_COUNT_WIDTH-1:0] c, input logic l);
    bus.desc_value  = v;
    bus.desc_count  = c;
    bus.desc_last   = l;
    bus.desc_tvalid = 1'b1;
    step();
    bus.desc_tvalid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] v, input logic l);
    check({tag, ".tvalid"}, 64'(bus.data_out_tvalid), 64'd1);
    check({tag, ".tdata"},  64'(bus.data_out_tdata),  64'(v));
    check({tag, ".tlast"},  64'(bus.data_out_tlast),  64'(l));
  endtask

  task automatic idle(input string tag, input logic done_exp);
    check({tag, ".tvalid"}, 64'(bus.data_out_tvalid), 64'd0);
    check({tag, ".done"},   64'(desc_done),            64'(done_exp));
  endtask

  logic bp_ready [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic bp_last  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n_xfer;
    reset = 1'b1;
    abort = 1'b0;
    bus.desc_tvalid     = 1'b0;
    bus.desc_value      = '0;
    bus.desc_count      = '0;
    bus.desc_last       = 1'b0;
    bus.data_out_tready = 1'b0;
    step();
    step();
    check("rst.desc_tready_in_reset", 64'(bus.desc_tready), 64'd0);
    reset = 1'b0;
    step();
    idle("rst", 1'b0);
    check("rst.tdata", 64'(bus.data_out_tdata), 64'd0);
    check("rst.tlast", 64'(bus.data_out_tlast), 64'd0);
    check("rst.busy",  64'(busy),               64'd0);
    check("rst.level", 64'(fifo_level),         64'd0);
    check("rst.desc_tready", 64'(bus.desc_tready), 64'd1);

    // Single burst with 2-cycle latency.
    bus.data_out_tready = 1'b1;
    push(8'hA5, 41'd3, 1'b1);
    idle("single.lat", 1'b0);
    check("single.level", 64'(fifo_level), 64'd1);
    step();
    beat("single.b1", 8'hA5, 1'b0);
    step();
    beat("single.b2", 8'hA5, 1'b0);
    step();
    beat("single.b3", 8'hA5, 1'b1);
    check("single.done_early", 64'(desc_done), 64'd0);
    step();
    idle("single.end", 1'b1);
    check("single.busy", 64'(busy), 64'd0);
    step();
    check("single.done_pulse", 64'(desc_done), 64'd0);

    // Back-to-back bursts with no bubble.
    push(8'h11, 41'd2, 1'b0);
    push(8'h22, 41'd1, 1'b1);
    beat("b2b.b1", 8'h11, 1'b0);
    step();
    beat("b2b.b2", 8'h11, 1'b0);
    step();
    beat("b2b.b3", 8'h22, 1'b1);
    check("b2b.done1", 64'(desc_done), 64'd1);
    step();
    idle("b2b.end", 1'b1);
    step();
    idle("b2b.after", 1'b0);

    // Backpressure pattern.
    bus.data_out_tready = 1'b0;
    push(8'h5A, 41'd4, 1'b1);
    step();
    n_xfer = 0;
    for (int i = 0; i < 7; i++) begin
      bus.data_out_tready = bp_ready[i];
      beat($sformatf("bp.c%0d", i), 8'h5A, bp_last[i]);
      if (bus.data_out_tvalid && bp_ready[i]) n_xfer++;
      step();
    end
    idle("bp.end", 1'b1);
    check("bp.n_xfer", 64'(n_xfer), 64'd4);

    // Zero-count descriptor followed by a one-beat burst.
    bus.data_out_tready = 1'b1;
    push(8'h33, 41'd0, 1'b1);
    push(8'h44, 41'd1, 1'b0);
    idle("zero.pop", 1'b1);
    check("zero.tlast", 64'(bus.data_out_tlast), 64'd0);
    step();
    beat("zero.b44", 8'h44, 1'b0);
    check("zero.done_off", 64'(desc_done), 64'd0);
    step();
    idle("zero.end", 1'b1);

    // Fill the queue behind a stalled burst.
    bus.data_out_tready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i), 41'd1, 1'b0);
    check("full.level", 64'(fifo_level), 64'd4);
    check("full.desc_tready", 64'(bus.desc_tready), 64'd0);
    check("full.busy", 64'(busy), 64'd1);
    beat("full.head", 8'h01, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle("full.abort", 1'b0);
    check("full.abort_level", 64'(fifo_level), 64'd0);

    // Abort mid-burst with two descriptors queued.
    bus.data_out_tready = 1'b1;
    push(8'h77, 41'd10, 1'b1);
    push(8'h88, 41'd1, 1'b0);
    push(8'h99, 41'd1, 1'b1);
    check("abort.level", 64'(fifo_level), 64'd2);
    step();
    step();
    beat("abort.b4", 8'h77, 1'b0);
    abort = 1'b1;
    bus.data_out_tready = 1'b0;
    #1;
    check("abort.desc_tready", 64'(bus.desc_tready), 64'd0);
    step();
    abort = 1'b0;
    idle("abort.after", 1'b0);
    check("abort.tlast", 64'(bus.data_out_tlast), 64'd0);
    check("abort.level0", 64'(fifo_level), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    step();
    idle("abort.quiet", 1'b0);
    bus.data_out_tready = 1'b1;
    push(8'hC3, 41'd2, 1'b1);
    step();
    beat("abort.new1", 8'hC3, 1'b0);
    step();
    beat("abort.new2", 8'hC3, 1'b1);
    step();
    idle("abort.new_end", 1'b1);

    // Reset mid-stream.
    push(8'hE1, 41'd5, 1'b1);
    step();
    beat("rst2.b1", 8'hE1, 1'b0);
    reset = 1'b1;
    #1;
    check("rst2.desc_tready", 64'(bus.desc_tready), 64'd0);
    step();
    reset = 1'b0;
    idle("rst2", 1'b0);
    check("rst2.tdata", 64'(bus.data_out_tdata), 64'd0);
    check("rst2.tlast", 64'(bus.data_out_tlast), 64'd0);
    check("rst2.busy",  64'(busy),               64'd0);
    check("rst2.level", 64'(fifo_level),         64'd0);

    // Maximal count: decrement without wrap, then shortcut to the last beat.
    push(8'h5C, MAX_COUNT, 1'b1);
    step();
    beat("max.b1", 8'h5C, 1'b0);
    check("max.rem0", 64'(dut.remaining), 64'(MAX_COUNT));
    step();
    check("max.rem1", 64'(dut.remaining), 64'h1FF_FFFF_FFFE);
    step();
    check("max.rem2", 64'(dut.remaining), 64'h1FF_FFFF_FFFD);
    force dut.remaining = 41'd1;
    #1;
    beat("max.final", 8'h5C, 1'b1);
    step();
    release dut.remaining;
    idle("max.end", 1'b1);
    check("max.busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
